// File: rtl/score_pkg.sv
// score_pkg: shared types and encodings for the scoreboard sequencing controller
package score_pkg;
  typedef enum logic {OP_INC, OP_DEC} op_t;
  typedef enum logic {S_IDLE, S_EXEC} state_t;
  localparam logic TEAM_A = 1'b0;
  localparam logic TEAM_B = 1'b1;
  localparam logic [1:0] LEAD_TIE = 2'b00;
  localparam logic [1:0] LEAD_A = 2'b01;
  localparam logic [1:0] LEAD_B = 2'b10;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability debounce and one-cycle press pulse on rising level
module btn_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEB_CYC + 1);
  logic s1, s2, level, level_d;
  logic [CW-1:0] cnt;
  // level flips only after DEB_CYC consecutive disagreeing samples; any agreement restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      level_d <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      level_d <= level;
      press <= level & ~level_d;
      if (s2 != level) begin
        if (cnt == CW'(DEB_CYC - 1)) begin
          level <= s2;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end else cnt <= '0;
    end
  end
endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: debounced per-team inc/dec requests arbitrated round-robin onto one saturating +/-1 unit
module score_ctrl
  import score_pkg::*;
#(
  parameter int SCORE_W = 8,
  parameter int MAX_SCORE = 99,
  parameter int DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_a_inc,
  input  logic btn_a_dec,
  input  logic btn_b_inc,
  input  logic btn_b_dec,
  input  logic btn_clr,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic upd_valid,
  output logic upd_team,
  output logic upd_sat,
  output logic [1:0] leader
);
  localparam logic [SCORE_W-1:0] MAX = SCORE_W'(MAX_SCORE);
  logic [4:0] raw, press;
  logic [1:0] pend;
  op_t pend_op_a, pend_op_b, op;
  state_t state;
  logic grant, last_grant, sat;
  logic [SCORE_W-1:0] cur, nxt;
  assign raw = {btn_clr, btn_b_dec, btn_b_inc, btn_a_dec, btn_a_inc};
  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn (
      .clk(clk),
      .rst_n(rst_n),
      .raw(raw[i]),
      .press(press[i])
    );
  end
  always_comb begin
    cur = grant ? score_b : score_a;
    op = grant ? pend_op_b : pend_op_a;
    sat = (op == OP_INC) ? (cur == MAX) : (cur == '0);
    nxt = sat ? cur : (op == OP_INC) ? cur + 1'b1 : cur - 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_a <= '0;
      score_b <= '0;
      upd_valid <= 1'b0;
      upd_team <= 1'b0;
      upd_sat <= 1'b0;
      leader <= LEAD_TIE;
      pend <= 2'b00;
      pend_op_a <= OP_INC;
      pend_op_b <= OP_INC;
      state <= S_IDLE;
      grant <= TEAM_A;
      last_grant <= TEAM_B;
    end else begin
      upd_valid <= 1'b0;
      leader <= (score_a > score_b) ? LEAD_A : (score_b > score_a) ? LEAD_B : LEAD_TIE;
      if (ena) begin
        if (press[4]) begin
          score_a <= '0;
          score_b <= '0;
          pend <= 2'b00;
          state <= S_IDLE;
        end else begin
          // simultaneous inc+dec for one team cancel out; a press onto a pending team is dropped
          if ((press[0] ^ press[1]) && !pend[0]) begin
            pend[0] <= 1'b1;
            pend_op_a <= press[1] ? OP_DEC : OP_INC;
          end
          if ((press[2] ^ press[3]) && !pend[1]) begin
            pend[1] <= 1'b1;
            pend_op_b <= press[3] ? OP_DEC : OP_INC;
          end
          if (state == S_IDLE) begin
            if (|pend) begin
              state <= S_EXEC;
              grant <= (&pend) ? ~last_grant : pend[1];
            end
          end else begin
            if (grant == TEAM_A) score_a <= nxt;
            else score_b <= nxt;
            upd_valid <= 1'b1;
            upd_team <= grant;
            upd_sat <= sat;
            pend[grant] <= 1'b0;
            last_grant <= grant;
            state <= S_IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed checks of debounce latency, arbitration, saturation, clear, enable and reset
module tb_score_ctrl;
  import score_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic btn_a_inc = 1'b0, btn_a_dec = 1'b0, btn_b_inc = 1'b0, btn_b_dec = 1'b0, btn_clr = 1'b0;
  logic [7:0] score_a, score_b;
  logic upd_valid, upd_team, upd_sat;
  logic [1:0] leader;
  int total = 0;
  int bad = 0;
  int nupd = 0;
  int base;
  score_ctrl #(.SCORE_W(8), .MAX_SCORE(99), .DEB_CYC(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .btn_a_inc(btn_a_inc),
    .btn_a_dec(btn_a_dec),
    .btn_b_inc(btn_b_inc),
    .btn_b_dec(btn_b_dec),
    .btn_clr(btn_clr),
    .score_a(score_a),
    .score_b(score_b),
    .upd_valid(upd_valid),
    .upd_team(upd_team),
    .upd_sat(upd_sat),
    .leader(leader)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (upd_valid) nupd++;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic set_btn(input logic [4:0] m);
    {btn_clr, btn_b_dec, btn_b_inc, btn_a_dec, btn_a_inc} = m;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask
  initial begin
    step(3);
    chk("rst_score_a", 32'(score_a), 0);
    chk("rst_score_b", 32'(score_b), 0);
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_leader", 32'(leader), 0);
    rst_n = 1'b1;
    step(2);
    // clean A inc: press pulse at edge 7, pending at 8, EXEC at 9, write at 10
    base = nupd;
    set_btn(5'b00001);
    step(6);
    chk("press_early", 32'(dut.g_btn[0].u_btn.press), 0);
    step(1);
    chk("press_lat7", 32'(dut.g_btn[0].u_btn.press), 1);
    step(2);
    chk("a_upd_early", 32'(upd_valid), 0);
    step(1);
    chk("a_upd_valid", 32'(upd_valid), 1);
    chk("a_upd_team", 32'(upd_team), 0);
    chk("a_upd_sat", 32'(upd_sat), 0);
    chk("a_score", 32'(score_a), 1);
    step(1);
    chk("a_leader", 32'(leader), 32'(LEAD_A));
    chk("a_upd_pulse", 32'(upd_valid), 0);
    set_btn(5'b0);
    step(15);
    chk("a_one_update", 32'(nupd - base), 1);
    // B glitches shorter than the debounce window
    base = nupd;
    set_btn(5'b00100);
    step(3);
    set_btn(5'b0);
    step(2);
    set_btn(5'b00100);
    step(3);
    set_btn(5'b0);
    step(15);
    chk("glitch_score_b", 32'(score_b), 0);
    chk("glitch_no_upd", 32'(nupd - base), 0);
    // simultaneous requests from reset: A first, B two cycles later
    do_reset();
    set_btn(5'b00101);
    step(10);
    chk("sim1_first_valid", 32'(upd_valid), 1);
    chk("sim1_first_team", 32'(upd_team), 0);
    chk("sim1_score_a", 32'(score_a), 1);
    step(1);
    chk("sim1_gap", 32'(upd_valid), 0);
    step(1);
    chk("sim1_second_valid", 32'(upd_valid), 1);
    chk("sim1_second_team", 32'(upd_team), 1);
    chk("sim1_score_b", 32'(score_b), 1);
    set_btn(5'b0);
    step(15);
    set_btn(5'b00001);
    step(10);
    chk("solo_a_score", 32'(score_a), 2);
    set_btn(5'b0);
    step(15);
    // last grant is now A, so B wins the tie
    set_btn(5'b00110);
    step(10);
    chk("sim2_first_team", 32'(upd_team), 1);
    chk("sim2_score_b", 32'(score_b), 2);
    step(2);
    chk("sim2_second_team", 32'(upd_team), 0);
    chk("sim2_score_a", 32'(score_a), 1);
    step(1);
    chk("sim2_leader", 32'(leader), 32'(LEAD_B));
    set_btn(5'b0);
    step(15);
    // saturation at both bounds
    do_reset();
    base = nupd;
    for (int i = 0; i < 99; i++) begin
      set_btn(5'b00001);
      step(6);
      set_btn(5'b0);
      step(6);
    end
    step(15);
    chk("preload_score_a", 32'(score_a), 99);
    chk("preload_updates", 32'(nupd - base), 99);
    chk("preload_leader", 32'(leader), 32'(LEAD_A));
    set_btn(5'b00001);
    step(10);
    chk("sat_hi_valid", 32'(upd_valid), 1);
    chk("sat_hi_flag", 32'(upd_sat), 1);
    chk("sat_hi_score", 32'(score_a), 99);
    set_btn(5'b0);
    step(15);
    set_btn(5'b01000);
    step(10);
    chk("sat_lo_valid", 32'(upd_valid), 1);
    chk("sat_lo_flag", 32'(upd_sat), 1);
    chk("sat_lo_team", 32'(upd_team), 1);
    chk("sat_lo_score", 32'(score_b), 0);
    set_btn(5'b0);
    step(15);
    // clear press lands in the same cycle as A's EXEC
    base = nupd;
    set_btn(5'b00001);
    step(2);
    set_btn(5'b10001);
    step(7);
    chk("clr_in_exec", 32'(dut.state), 32'(S_EXEC));
    step(1);
    chk("clr_upd_valid", 32'(upd_valid), 0);
    chk("clr_score_a", 32'(score_a), 0);
    chk("clr_score_b", 32'(score_b), 0);
    chk("clr_state", 32'(dut.state), 32'(S_IDLE));
    chk("clr_pend", 32'(dut.pend), 0);
    set_btn(5'b0);
    step(15);
    chk("clr_no_upd", 32'(nupd - base), 0);
    chk("clr_hold_a", 32'(score_a), 0);
    // ena low swallows a B press
    base = nupd;
    ena = 1'b0;
    set_btn(5'b00100);
    step(10);
    chk("ena_upd_valid", 32'(upd_valid), 0);
    set_btn(5'b0);
    step(15);
    ena = 1'b1;
    step(5);
    chk("ena_score_b", 32'(score_b), 0);
    chk("ena_no_upd", 32'(nupd - base), 0);
    // pending captured before ena drops is applied once ena returns
    set_btn(5'b00001);
    step(8);
    ena = 1'b0;
    step(10);
    set_btn(5'b0);
    chk("hold_score_a", 32'(score_a), 0);
    chk("hold_pend_a", 32'(dut.pend[0]), 1);
    chk("hold_state", 32'(dut.state), 32'(S_IDLE));
    ena = 1'b1;
    step(1);
    chk("resume_exec", 32'(dut.state), 32'(S_EXEC));
    step(1);
    chk("resume_valid", 32'(upd_valid), 1);
    chk("resume_score_a", 32'(score_a), 1);
    step(5);
    chk("resume_leader", 32'(leader), 32'(LEAD_A));
    // asynchronous reset while B is in EXEC
    set_btn(5'b00100);
    step(9);
    chk("arst_in_exec", 32'(dut.state), 32'(S_EXEC));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_score_a", 32'(score_a), 0);
    chk("arst_score_b", 32'(score_b), 0);
    chk("arst_leader", 32'(leader), 0);
    chk("arst_upd_valid", 32'(upd_valid), 0);
    chk("arst_state", 32'(dut.state), 32'(S_IDLE));
    set_btn(5'b0);
    step(2);
    rst_n = 1'b1;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Sequencing controller for the scoreboard's score datapath.
- Takes five raw push-button inputs: per-team increment/decrement plus game clear. Synchronises and debounces them, then queues one pending operation per team.
- Round-robin arbitration gives both teams access to a single shared saturating add/subtract unit.
- Sits between the top-level ui_in pins and the score registers that drive uo_out/uio_out.

Parameters:
- SCORE_W, 8, width of each score register.
- MAX_SCORE, 99, saturation ceiling; must be < 2**SCORE_W.
- DEB_CYC, 4, consecutive stable synchronised samples needed to accept a new button level (>= 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; low freezes capture and FSM.
- btn_a_inc  in  1  raw, asynchronous; team A +1.
- btn_a_dec  in  1  raw, asynchronous; team A -1.
- btn_b_inc  in  1  raw, asynchronous; team B +1.
- btn_b_dec  in  1  raw, asynchronous; team B -1.
- btn_clr  in  1  raw, asynchronous; clear game.
- score_a  out  SCORE_W  team A score.
- score_b  out  SCORE_W  team B score.
- upd_valid  out  1  one-cycle pulse when a score write is applied.
- upd_team  out  1  team written; 0 = A, 1 = B. Valid with upd_valid.
- upd_sat  out  1  operation saturated (no change). Valid with upd_valid.
- leader  out  2  01 = A ahead, 10 = B ahead, 00 = tie.

Behaviour:
- Reset (rst_n low, async):
  - Scores 0, upd_valid/upd_team/upd_sat 0, leader 00.
  - Synchronisers, debounce counters and debounced levels 0; pending flags cleared.
  - FSM in IDLE; last_grant = B, so A wins the first tie.
- Input path, per button:
  - 2-flop synchroniser, then debounce counter.
  - The debounced level changes only after DEB_CYC consecutive synchronised samples differ from it. Any glitch back to the current level resets the counter.
  - A rising edge of the debounced level is a "press".
  - Press latency from a clean raw edge is 2 + DEB_CYC + 1 cycles.
- Pending, per team: pend_vld and pend_op (INC/DEC).
  - Press while not pending: set pend_vld, record op.
  - inc and dec presses in the same cycle: both ignored.
  - Press while already pending: dropped; the pending op is unchanged.
- FSM states: IDLE, EXEC.
  - IDLE -> EXEC when any pend_vld = 1.
    - Grant: the only requester; if both request, the team opposite last_grant.
    - Register the grant.
  - EXEC, one cycle, on the granted team:
    - INC: if score == MAX_SCORE, hold and set upd_sat = 1; else score + 1.
    - DEC: if score == 0, hold and set upd_sat = 1; else score - 1.
    - Pulse upd_valid with upd_team = grant.
    - Clear that team's pend_vld; set last_grant = grant; go to IDLE.
  - Throughput: one update per 2 cycles.
  - A press for the granted team arriving in the EXEC cycle is dropped.
- Game clear: a debounced btn_clr press has priority over everything in that cycle.
  - Scores go to 0 and both pending flags clear.
  - FSM goes to IDLE; upd_valid stays 0; last_grant is unchanged.
- ena low:
  - No presses are captured; debounce state still tracks.
  - FSM and scores hold; upd_valid is 0.
  - Pending flags persist and resume when ena rises.
- leader:
  - Registered compare of the score registers; updates the cycle after a score write.
- Arithmetic:
  - Unsigned SCORE_W. The shared unit computes score ± 1 with explicit bounds checks; there is no wrap-around.

Decomposition:
- Package score_pkg holds:
  - op_t enum {OP_INC, OP_DEC}.
  - state_t enum {S_IDLE, S_EXEC}.
  - TEAM_A/TEAM_B constants.
  - LEAD_TIE/LEAD_A/LEAD_B encodings.
- Sub-module btn_debounce (synchroniser + debounce + press pulse, parameter DEB_CYC), instantiated five times.

Test Plan:
- Reset, then clean btn_a_inc press (held 10 cycles) -> exactly one upd_valid, upd_team = 0, score_a = 1, leader = 01; press latency = DEB_CYC + 3 cycles (7 at DEB_CYC = 4).
- Glitch: btn_b_inc high for 3 cycles (< DEB_CYC), low, then high for 3 cycles -> no update, score_b stays 0.
- Simultaneous: A and B inc presses in the same cycle from reset:
  - A is applied first (upd_team = 0), B two cycles later.
  - Repeat with last_grant = A -> B is applied first.
- Saturation: preload score_a = 99 via 99 presses, then inc -> upd_valid = 1, upd_sat = 1, score_a = 99. With score_b = 0, dec -> upd_sat = 1, score_b = 0.
- Clear mid-operation: A pending with FSM in EXEC and clr press in the same cycle -> scores 0, upd_valid = 0, pending cleared, FSM in IDLE.
- ena low during a B press -> no update; rst_n pulsed low mid-EXEC -> all outputs 0 asynchronously.
